// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the AXI4-Lite adder block:
//   - byte offsets of the four registers and their word indices (addr[3:2])
//   - AXI response codes
//   - bit positions inside the STATUS register
// No ports; imported by adder and adder_core.
// ----------------------------------------------------------------------------
package adder_pkg;

    // Register byte offsets
    localparam logic [3:0] OFFS_OPA    = 4'h0;
    localparam logic [3:0] OFFS_OPB    = 4'h4;
    localparam logic [3:0] OFFS_SUM    = 4'h8;
    localparam logic [3:0] OFFS_STATUS = 4'hC;

    // Word indices used by the decoder (offset bits [3:2])
    localparam logic [1:0] IDX_OPA    = OFFS_OPA[3:2];
    localparam logic [1:0] IDX_OPB    = OFFS_OPB[3:2];
    localparam logic [1:0] IDX_SUM    = OFFS_SUM[3:2];
    localparam logic [1:0] IDX_STATUS = OFFS_STATUS[3:2];

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // STATUS register bit positions
    localparam int STATUS_CARRY_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

endpackage : adder_pkg

// File: rtl/adder_core.sv
// ----------------------------------------------------------------------------
// adder_core
// Purely combinational datapath: sum of the two operands, wrapping modulo
// 2^WIDTH, plus unsigned carry-out and two's-complement overflow.
// Carry/overflow are only built when ADDER_STATUS_EN is defined; otherwise
// they are tied to 0.
// Ports:
//   opa, opb  in  [WIDTH-1:0]  operands
//   sum       out [WIDTH-1:0]  (opa + opb) mod 2^WIDTH
//   carry     out 1            unsigned carry-out of the addition
//   overflow  out 1            signed overflow of the addition
// ----------------------------------------------------------------------------
module adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

`ifdef ADDER_STATUS_EN
    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, opa} + {1'b0, opb};
    assign sum      = full_sum[WIDTH-1:0];
    assign carry    = full_sum[WIDTH];
    // Signed overflow: operands share a sign and the result's sign differs.
    assign overflow = (opa[WIDTH-1] == opb[WIDTH-1]) &&
                      (sum[WIDTH-1] != opa[WIDTH-1]);
`else
    assign sum      = opa + opb;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule : adder_core

// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder
// AXI4-Lite slave exposing a 32-bit adder:
//   0x00 OPA (RW), 0x04 OPB (RW), 0x08 SUM (RO), 0x0C STATUS (RO)
// STATUS carries carry-out (bit0) and signed overflow (bit1) only when the
// macro ADDER_STATUS_EN is defined; otherwise it reads as 0.
// Addresses with any bit above [3] set are unmapped: writes are dropped,
// reads return 0. All responses are OKAY.
// Ports (AXI4-Lite slave, prefix s2_axi_):
//   aclk, aresetn (async, active-low)
//   aw: awaddr/awvalid/awready   w: wdata/wstrb/wvalid/wready
//   b:  bresp/bvalid/bready      ar: araddr/arvalid/arready
//   r:  rdata/rresp/rvalid/rready
// ----------------------------------------------------------------------------
module adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      s2_axi_aclk,
    input  logic                      s2_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s2_axi_awaddr,
    input  logic                      s2_axi_awvalid,
    output logic                      s2_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s2_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s2_axi_wstrb,
    input  logic                      s2_axi_wvalid,
    output logic                      s2_axi_wready,
    output logic [1:0]                s2_axi_bresp,
    output logic                      s2_axi_bvalid,
    input  logic                      s2_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s2_axi_araddr,
    input  logic                      s2_axi_arvalid,
    output logic                      s2_axi_arready,
    output logic [DATA_WIDTH-1:0]     s2_axi_rdata,
    output logic [1:0]                s2_axi_rresp,
    output logic                      s2_axi_rvalid,
    input  logic                      s2_axi_rready
);

    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic [DATA_WIDTH-1:0] sum_val;
    logic [DATA_WIDTH-1:0] status_val;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  carry;
    logic                  overflow;
    logic                  aw_w_ready;
    logic                  wr_en;
    logic                  rd_en;
    logic                  aw_mapped;
    logic                  ar_mapped;
    logic                  unused_addr_bits;

    // Registers are word-aligned; byte-offset bits carry no information.
    assign unused_addr_bits = &{1'b0, s2_axi_awaddr[1:0], s2_axi_araddr[1:0]};

    assign aw_mapped = (s2_axi_awaddr[ADDR_WIDTH-1:4] == '0);
    assign ar_mapped = (s2_axi_araddr[ADDR_WIDTH-1:4] == '0);

    // AW and W are accepted together, so one register drives both readies.
    assign s2_axi_awready = aw_w_ready;
    assign s2_axi_wready  = aw_w_ready;
    assign wr_en          = aw_w_ready && s2_axi_awvalid && s2_axi_wvalid;
    assign rd_en          = s2_axi_arready && s2_axi_arvalid;

    assign s2_axi_bresp = RESP_OKAY;
    assign s2_axi_rresp = RESP_OKAY;

    adder_core #(
        .WIDTH (DATA_WIDTH)
    ) u_core (
        .opa      (opa),
        .opb      (opb),
        .sum      (sum_val),
        .carry    (carry),
        .overflow (overflow)
    );

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        status_val                   = '0;
        status_val[STATUS_CARRY_BIT] = carry;
        status_val[STATUS_OVF_BIT]   = overflow;
    end

    always_comb begin
        rd_value = '0;
        if (ar_mapped) begin
            case (s2_axi_araddr[3:2])
                IDX_OPA:    rd_value = opa;
                IDX_OPB:    rd_value = opb;
                IDX_SUM:    rd_value = sum_val;
                IDX_STATUS: rd_value = status_val;
            endcase
        end
    end

    // Handshake and response channels. Readies are registered one-cycle
    // pulses so they are low during reset regardless of the valids.
    // NOTE: state is updated with non-blocking assignments only; a read that
    // is accepted on the same edge as a write therefore captures the old value.
    always_ff @(posedge s2_axi_aclk or negedge s2_axi_aresetn) begin
        if (!s2_axi_aresetn) begin
            aw_w_ready     <= 1'b0;
            s2_axi_bvalid  <= 1'b0;
            s2_axi_arready <= 1'b0;
            s2_axi_rvalid  <= 1'b0;
            s2_axi_rdata   <= '0;
        end else begin
            aw_w_ready <= !aw_w_ready && s2_axi_awvalid && s2_axi_wvalid &&
                          !s2_axi_bvalid;

            if (wr_en) begin
                s2_axi_bvalid <= 1'b1;
            end else if (s2_axi_bready) begin
                s2_axi_bvalid <= 1'b0;
            end

            s2_axi_arready <= !s2_axi_arready && s2_axi_arvalid &&
                              !s2_axi_rvalid;

            if (rd_en) begin
                s2_axi_rvalid <= 1'b1;
                s2_axi_rdata  <= rd_value;
            end else if (s2_axi_rready) begin
                s2_axi_rvalid <= 1'b0;
            end
        end
    end

    // Operand registers with per-byte strobes; SUM/STATUS/unmapped are dropped.
    always_ff @(posedge s2_axi_aclk or negedge s2_axi_aresetn) begin
        if (!s2_axi_aresetn) begin
            opa <= '0;
            opb <= '0;
        end else if (wr_en && aw_mapped) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (s2_axi_wstrb[b]) begin
                    if (s2_axi_awaddr[3:2] == IDX_OPA) begin
                        opa[8*b +: 8] <= s2_axi_wdata[8*b +: 8];
                    end else if (s2_axi_awaddr[3:2] == IDX_OPB) begin
                        opb[8*b +: 8] <= s2_axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule : adder

// File: tb/tb_adder.sv
// ----------------------------------------------------------------------------
// tb_adder
// Directed self-checking bench for the AXI4-Lite adder. Expected values are
// hand-computed constants; STATUS expectations depend on ADDER_STATUS_EN.
// ----------------------------------------------------------------------------
module tb_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef ADDER_STATUS_EN
    localparam logic [31:0] EXP_ST_CARRY = 32'h1;
    localparam logic [31:0] EXP_ST_OVF   = 32'h2;
`else
    localparam logic [31:0] EXP_ST_CARRY = 32'h0;
    localparam logic [31:0] EXP_ST_OVF   = 32'h0;
`endif

    always #5 clk = ~clk;

    adder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .s2_axi_aclk    (clk),
        .s2_axi_aresetn (rst_n),
        .s2_axi_awaddr  (awaddr),
        .s2_axi_awvalid (awvalid),
        .s2_axi_awready (awready),
        .s2_axi_wdata   (wdata),
        .s2_axi_wstrb   (wstrb),
        .s2_axi_wvalid  (wvalid),
        .s2_axi_wready  (wready),
        .s2_axi_bresp   (bresp),
        .s2_axi_bvalid  (bvalid),
        .s2_axi_bready  (bready),
        .s2_axi_araddr  (araddr),
        .s2_axi_arvalid (arvalid),
        .s2_axi_arready (arready),
        .s2_axi_rdata   (rdata),
        .s2_axi_rresp   (rresp),
        .s2_axi_rvalid  (rvalid),
        .s2_axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed no handshake within 20 cycles expected handshake", tag);
    endtask

    // Presents AW+W and returns just after the accepting edge.
    task automatic start_write(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        bit ok = 0;
        @(negedge clk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin
                check("wready_with_awready", {31'b0, wready}, 32'h1);
                @(posedge clk);
                #1;
                awvalid = 1'b0;
                wvalid  = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            timeout("write_accept");
        end
    endtask

    // Waits for B, holds bready low for 'hold' cycles while re-presenting the
    // write (which must not be accepted), then consumes the response.
    task automatic finish_write(input int hold);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            timeout("bvalid");
        end else begin
            check("bresp", {30'b0, bresp}, 32'h0);
            if (hold > 0) begin
                awvalid = 1'b1;
                wvalid  = 1'b1;
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("bvalid_hold", {31'b0, bvalid}, 32'h1);
                check("awready_blocked", {31'b0, awready}, 32'h0);
                check("wready_blocked", {31'b0, wready}, 32'h0);
            end
            awvalid = 1'b0;
            wvalid  = 1'b0;
            bready  = 1'b1;
            @(posedge clk);
            #1;
            bready = 1'b0;
            check("bvalid_drop", {31'b0, bvalid}, 32'h0);
        end
    endtask

    task automatic write(input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int hold);
        start_write(addr, data, strb);
        finish_write(hold);
    endtask

    task automatic start_read(input logic [7:0] addr);
        bit ok = 0;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk);
                #1;
                arvalid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            arvalid = 1'b0;
            timeout("read_accept");
        end
    endtask

    task automatic finish_read(input string tag, input logic [31:0] exp,
                               input int hold);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            timeout(tag);
        end else begin
            check(tag, rdata, exp);
            check("rresp", {30'b0, rresp}, 32'h0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rvalid_hold", {31'b0, rvalid}, 32'h1);
                check("rdata_stable", rdata, exp);
            end
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = 1'b0;
            check("rvalid_drop", {31'b0, rvalid}, 32'h0);
        end
    endtask

    task automatic read(input string tag, input logic [7:0] addr,
                        input logic [31:0] exp, input int hold);
        start_read(addr);
        finish_read(tag, exp, hold);
    endtask

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state, with valids asserted to show readies stay low.
        repeat (2) @(negedge clk);
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_wready", {31'b0, wready}, 32'h0);
        check("rst_arready", {31'b0, arready}, 32'h0);
        check("rst_bvalid", {31'b0, bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bresp", {30'b0, bresp}, 32'h0);
        check("rst_rresp", {30'b0, rresp}, 32'h0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        rst_n   = 1'b1;

        read("sum_after_reset", 8'h08, 32'h0, 0);

        // Basic sums
        write(8'h00, 32'd23, 4'hF, 0);
        write(8'h04, 32'd30, 4'hF, 0);
        read("sum_23_30", 8'h08, 32'd53, 0);
        write(8'h00, 32'd37, 4'hF, 0);
        write(8'h04, 32'd44, 4'hF, 0);
        read("sum_37_44", 8'h08, 32'd81, 0);
        read("opa_37", 8'h00, 32'd37, 0);

        // Wrap and status
        write(8'h00, 32'hFFFF_FFFF, 4'hF, 0);
        write(8'h04, 32'h0000_0001, 4'hF, 0);
        read("sum_wrap", 8'h08, 32'h0, 0);
        read("status_carry", 8'h0C, EXP_ST_CARRY, 0);
        write(8'h00, 32'h7FFF_FFFF, 4'hF, 0);
        read("sum_ovf", 8'h08, 32'h8000_0000, 0);
        read("status_ovf", 8'h0C, EXP_ST_OVF, 0);

        // Byte strobes
        write(8'h00, 32'h1122_3344, 4'hF, 0);
        write(8'h00, 32'hAABB_CCDD, 4'h5, 0);
        read("opa_strobe", 8'h00, 32'h11BB_33DD, 0);

        // Write response back-pressure
        write(8'h04, 32'd5, 4'hF, 3);
        read("opb_after_hold", 8'h04, 32'd5, 0);

        // Reads with rready held off, unmapped and read-only addresses
        read("unmapped_0x10", 8'h10, 32'h0, 2);
        read("sum_mixed", 8'h08, 32'h11BB_33E2, 1);
        read("unmapped_0x40", 8'h40, 32'h0, 0);
        write(8'h08, 32'h1234_5678, 4'hF, 0);
        read("sum_ro", 8'h08, 32'h11BB_33E2, 0);
        write(8'h0C, 32'hFFFF_FFFF, 4'hF, 0);
        read("status_ro", 8'h0C, 32'h0, 0);
        write(8'h14, 32'h0000_0099, 4'hF, 0);
        read("opb_alias_ignored", 8'h04, 32'd5, 0);

        // Same-edge write and read of OPA returns the old value
        fork
            write(8'h00, 32'hCAFE_F00D, 4'hF, 0);
            read("opa_same_edge_old", 8'h00, 32'h11BB_33DD, 0);
        join
        read("opa_new", 8'h00, 32'hCAFE_F00D, 0);

        // Read accepted the cycle after a write accept sees the new sum
        fork
            write(8'h04, 32'h0000_0010, 4'hF, 0);
            begin
                @(negedge clk);
                read("sum_next_cycle", 8'h08, 32'hCAFE_F01D, 0);
            end
        join

        // Reset with B and R responses pending
        start_write(8'h00, 32'h0000_DEAD, 4'hF);
        start_read(8'h04);
        @(negedge clk);
        check("pend_bvalid", {31'b0, bvalid}, 32'h1);
        check("pend_rvalid", {31'b0, rvalid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_bvalid", {31'b0, bvalid}, 32'h0);
        check("abort_rvalid", {31'b0, rvalid}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", {31'b0, bvalid}, 32'h0);
            check("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
        end
        read("opa_after_rst", 8'h00, 32'h0, 0);
        read("opb_after_rst", 8'h04, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adder
